fp_add_sequencer: RTL and testbench

- Multi-cycle controller that sequences an IEEE-754 single-precision add over one shared datapath.
- Stages run one per clock: unpack/swap, exponent-difference align, mantissa add/subtract, iterative normalise, pack.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Replaces the combinational adder where timing closure needs a short critical path.

---
 rtl/fp_add_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single-precision adder.
// One shared datapath steps through unpack/swap, align, add, normalise, pack.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   operand1, operand2  IEEE-754 operands
//   sub                 FP_ADD_SUB_EN only: 1 computes operand1-operand2
//   out_valid/out_ready result handshake (result held until accepted)
//   result              IEEE-754 sum
//   busy                high whenever not IDLE
//
// Optional feature macro: FP_ADD_SUB_EN (adds the sub port).
// Rounding is truncation: no guard, round or sticky bits are kept.
module fp_add_sequencer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     operand1,
  input  logic [EXP_W+MAN_W:0]     operand2,
`ifdef FP_ADD_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     busy
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;

  localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] E_MAX = '1;
  localparam logic [EXP_W-1:0] E_MW  = EXP_W'(MW);

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, PACK, DONE
  } state_t;

  state_t state_q, state_d;

  logic             sgn_q, sgn_d;
  logic             sgn_b_q, sgn_b_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] exp_b_q, exp_b_d;
  logic [MW-1:0]    man_a_q, man_a_d;
  logic [MW-1:0]    man_b_q, man_b_d;
  logic [MW:0]      acc_q, acc_d;
  logic [W-1:0]     res_q, res_d;

  // Capture-side unpack and swap
  logic             sub_bit;
  logic [W-1:0]     op_b;
  logic             swap;
  logic [W-1:0]     a_w, b_w;
  logic [EXP_W-1:0] a_e, b_e;
  logic             nan_a, nan_b;
  logic             inf_a, inf_b;
  logic             special;
  logic [W-1:0]     spec_val;

`ifdef FP_ADD_SUB_EN
  assign sub_bit = sub;
`else
  assign sub_bit = 1'b0;
`endif

  assign op_b = {operand2[W-1] ^ sub_bit, operand2[W-2:0]};
  // Tie keeps operand1 as A
  assign swap = op_b[W-2:0] > operand1[W-2:0];
  assign a_w  = swap ? op_b : operand1;
  assign b_w  = swap ? operand1 : op_b;
  assign a_e  = a_w[W-2:MAN_W];
  assign b_e  = b_w[W-2:MAN_W];

  assign nan_a = (&a_e) && (|a_w[MAN_W-1:0]);
  assign nan_b = (&b_e) && (|b_w[MAN_W-1:0]);
  assign inf_a = (&a_e) && !(|a_w[MAN_W-1:0]);
  assign inf_b = (&b_e) && !(|b_w[MAN_W-1:0]);

  // A is the larger magnitude, so a non-NaN inf on B implies inf on A
  assign special = nan_a || nan_b || inf_a;

  always_comb begin
    spec_val = a_w;
    if (nan_a || nan_b ||
        (inf_a && inf_b && (a_w[W-1] != b_w[W-1])))
      spec_val = QNAN;
  end

  // Datapath helpers
  logic [EXP_W-1:0] diff;
  logic [MW:0]      sum;
  logic [MW:0]      shl;
  logic [EXP_W-1:0] exp_dec;
  logic [EXP_W-1:0] exp_fld;

  assign diff = exp_q - exp_b_q;
  assign sum  = (sgn_q == sgn_b_q)
              ? {1'b0, man_a_q} + {1'b0, man_b_q}
              : {1'b0, man_a_q} - {1'b0, man_b_q};
  assign shl     = {acc_q[MW-1:0], 1'b0};
  assign exp_dec = exp_q - E_ONE;
  // Missing hidden bit means denormal, except the inf encoding
  assign exp_fld = (acc_q[MAN_W] || (&exp_q)) ? exp_q : '0;

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    sgn_b_d   = sgn_b_q;
    exp_d     = exp_q;
    exp_b_d   = exp_b_q;
    man_a_d   = man_a_q;
    man_b_d   = man_b_q;
    acc_d     = acc_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          sgn_d   = a_w[W-1];
          sgn_b_d = b_w[W-1];
          exp_d   = a_e;
          exp_b_d = b_e;
          man_a_d = {|a_e, a_w[MAN_W-1:0]};
          man_b_d = {|b_e, b_w[MAN_W-1:0]};
          if (special) begin
            res_d   = spec_val;
            state_d = DONE;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        man_b_d = (diff >= E_MW) ? '0 : (man_b_q >> diff);
        state_d = ADD;
      end
      ADD: begin
        acc_d   = sum;
        state_d = PACK;
        if (sum[MW]) begin
          acc_d = sum >> 1;
          exp_d = exp_q + E_ONE;
          if (exp_q == E_MAX - E_ONE) begin
            acc_d = '0;
            exp_d = E_MAX;
          end
        end else if (sum == '0) begin
          sgn_d = 1'b0;
          exp_d = '0;
        end else if (!sum[MAN_W] && (exp_q > E_ONE)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        acc_d = shl;
        exp_d = exp_dec;
        if (shl[MAN_W] || (exp_dec == E_ONE))
          state_d = PACK;
      end
      PACK: begin
        res_d   = {sgn_q, exp_fld, acc_q[MAN_W-1:0]};
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q   <= 1'b0;
      sgn_b_q <= 1'b0;
      exp_q   <= '0;
      exp_b_q <= '0;
      man_a_q <= '0;
      man_b_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      sgn_q   <= sgn_d;
      sgn_b_q <= sgn_b_d;
      exp_q   <= exp_d;
      exp_b_q <= exp_b_d;
      man_a_q <= man_a_d;
      man_b_q <= man_b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: scoreboard bench for fp_add_sequencer.
// Driver pushes expected result+latency; monitor checks on out_valid.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
`ifdef FP_ADD_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  fp_add_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
`ifdef FP_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int          lat;
    int          stamp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] e;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vt[$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  // Monitor: samples on the falling edge
  initial begin
    bit ov_seen = 1'b0;
    bit hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_seen = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
          chk("in_ready_back", {31'b0, in_ready}, 32'd1);
          hs_prev = 1'b0;
        end
        if (ov_seen && !out_valid) begin
          chk("out_valid_held", 32'd0, 32'd1);
          ov_seen = 1'b0;
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", {31'b0, out_valid}, 32'd0);
          end else begin
            if (!ov_seen) begin
              chk({sb[0].nm, "_lat"}, 32'(cyc - sb[0].stamp),
                  32'(sb[0].lat));
              ov_seen = 1'b1;
            end
            if (!out_ready) begin
              chk({sb[0].nm, "_stall_res"}, result, sb[0].res);
              chk({sb[0].nm, "_stall_rdy"}, {31'b0, in_ready}, 32'd0);
              chk({sb[0].nm, "_stall_busy"}, {31'b0, busy}, 32'd1);
            end else begin
              chk({sb[0].nm, "_res"}, result, sb[0].res);
              void'(sb.pop_front());
              ov_seen = 1'b0;
              hs_prev = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (!in_ready)
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send(vec_t v);
    int t = 0;
    step();
    wait_ready();
    in_valid  = 1'b1;
    operand1  = v.a;
    operand2  = v.b;
`ifdef FP_ADD_SUB_EN
    sub       = v.s;
`endif
    out_ready = (v.hold == 0);
    sb.push_back('{v.nm, v.e, v.lat, cyc});
    step();
    in_valid = 1'b0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    if (!out_valid) begin
      chk({v.nm, "_timeout"}, {31'b0, out_valid}, 32'd1);
      sb.delete();
    end
    repeat (v.hold) step();
    out_ready = 1'b1;
    t = 0;
    while (out_valid && t < 50) begin
      step();
      t++;
    end
  endtask

  initial begin
    vt.push_back('{"add20m10", 32'h41A00000, 32'hC1200000, 1'b0,
                   32'h41200000, 5, 0});
    vt.push_back('{"one_one", 32'h3F800000, 32'h3F800000, 1'b0,
                   32'h40000000, 4, 5});
    vt.push_back('{"inf_one", 32'h7F800000, 32'h3F800000, 1'b0,
                   32'h7F800000, 1, 0});
    vt.push_back('{"inf_minf", 32'h7F800000, 32'hFF800000, 1'b0,
                   32'h7FC00000, 1, 0});
    vt.push_back('{"one_mone", 32'h3F800000, 32'hBF800000, 1'b0,
                   32'h00000000, 4, 0});
    vt.push_back('{"swap", 32'h3F800000, 32'hC0000000, 1'b0,
                   32'hBF800000, 5, 0});
    vt.push_back('{"nan", 32'h7FC00001, 32'h3F800000, 1'b0,
                   32'h7FC00000, 1, 0});
    vt.push_back('{"neg_inf", 32'h3F800000, 32'hFF800000, 1'b0,
                   32'hFF800000, 1, 0});
    vt.push_back('{"overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0,
                   32'h7F800000, 4, 0});
    vt.push_back('{"denorm", 32'h01000000, 32'h80C00000, 1'b0,
                   32'h00400000, 5, 0});
    vt.push_back('{"big_d", 32'h4B800000, 32'h3F800000, 1'b0,
                   32'h4B800000, 4, 0});
    vt.push_back('{"norm23", 32'h3F800000, 32'hBF7FFFFF, 1'b0,
                   32'h34000000, 27, 0});
`ifdef FP_ADD_SUB_EN
    vt.push_back('{"sub_2m1", 32'h40000000, 32'h3F800000, 1'b1,
                   32'h3F800000, 5, 0});
    vt.push_back('{"sub_1m1", 32'h3F800000, 32'h3F800000, 1'b1,
                   32'h00000000, 4, 0});
`endif

    repeat (3) step();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;

    foreach (vt[i]) send(vt[i]);

    // Reset in the middle of a long normalise
    step();
    wait_ready();
    in_valid = 1'b1;
    operand1 = 32'h3F800000;
    operand2 = 32'hBF7FFFFF;
`ifdef FP_ADD_SUB_EN
    sub      = 1'b0;
`endif
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("norm_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    rst = 1'b0;
    repeat (40) step();
    chk("mid_rst_idle", {31'b0, busy}, 32'd0);

    if (sb.size() != 0)
      chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
